// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg -- shared definitions for the streaming 4-point FFT (fft4_stream).
//   state_t     : frame sequencer states (LOAD, STAGE1, STAGE2, UNLOAD)
//   FFT4_N      : frame size (4 samples / 4 bins)
//   IDX_W       : width of the sample / bin index
//   SCALE_EN    : 1 when built with FFT4_SCALE_EN (per-stage >>1 scaling)
//   out_width() : output component width for a given input width
// Optional feature macro: FFT4_SCALE_EN.
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT4_N = 4;
   localparam int IDX_W  = $clog2(FFT4_N);

`ifdef FFT4_SCALE_EN
   localparam bit SCALE_EN = 1'b1;
`else
   localparam bit SCALE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      STAGE1 = 2'd1,
      STAGE2 = 2'd2,
      UNLOAD = 2'd3
   } state_t;

   // Two butterfly stages each add one bit of growth, unless every stage
   // halves its result, in which case the width is preserved end to end.
   function automatic int out_width(input int dw);
      return SCALE_EN ? dw : dw + 2;
   endfunction

endpackage

// File: rtl/fft_bfly2.sv
// -----------------------------------------------------------------------------
// fft_bfly2 -- combinational complex radix-2 butterfly.
//   sum = a + b, dif = a - b, both computed at IN_W+1 bits so the add itself
//   can never wrap. With FFT4_SCALE_EN defined the full-width result is
//   arithmetic-shifted right by 1 (floor toward -inf) before narrowing.
// Parameters:
//   IN_W  : signed input component width
//   OUT_W : signed output component width (caller guarantees the value fits)
// Ports:
//   a_re, a_im, b_re, b_im     in  IN_W   operands
//   sum_re, sum_im             out OUT_W  a + b
//   dif_re, dif_im             out OUT_W  a - b
// Optional feature macro: FFT4_SCALE_EN.
// -----------------------------------------------------------------------------
module fft_bfly2 #(
   parameter int IN_W  = 17,
   parameter int OUT_W = 18
) (
   input  logic signed [IN_W-1:0]  a_re,
   input  logic signed [IN_W-1:0]  a_im,
   input  logic signed [IN_W-1:0]  b_re,
   input  logic signed [IN_W-1:0]  b_im,
   output logic signed [OUT_W-1:0] sum_re,
   output logic signed [OUT_W-1:0] sum_im,
   output logic signed [OUT_W-1:0] dif_re,
   output logic signed [OUT_W-1:0] dif_im
);

   localparam int FW = IN_W + 1;

   logic signed [FW-1:0] s_re, s_im, d_re, d_im;

   // Sign-extend before adding so the full-precision result is exact.
   assign s_re = FW'(a_re) + FW'(b_re);
   assign s_im = FW'(a_im) + FW'(b_im);
   assign d_re = FW'(a_re) - FW'(b_re);
   assign d_im = FW'(a_im) - FW'(b_im);

`ifdef FFT4_SCALE_EN
   assign sum_re = OUT_W'(s_re >>> 1);
   assign sum_im = OUT_W'(s_im >>> 1);
   assign dif_re = OUT_W'(d_re >>> 1);
   assign dif_im = OUT_W'(d_im >>> 1);
`else
   assign sum_re = OUT_W'(s_re);
   assign sum_im = OUT_W'(s_im);
   assign dif_re = OUT_W'(d_re);
   assign dif_im = OUT_W'(d_im);
`endif

endmodule

// File: rtl/fft4_stream.sv
// -----------------------------------------------------------------------------
// fft4_stream -- sample-serial, pipelined 4-point radix-2 DIT DFT.
//   Buffers a 4-sample frame, runs two registered butterfly stages (forward
//   or inverse, chosen by in_inverse on sample 0) and streams the 4 bins out
//   in natural order under out_ready backpressure. One frame in flight.
// Parameters:
//   DATA_W : signed input component width
//   OUT_W  : output width, DATA_W+2 (unscaled) or DATA_W (FFT4_SCALE_EN)
// Ports:
//   clk, rst_n          in   clock, async active-low reset
//   in_valid/in_ready   in/out input sample handshake
//   in_re, in_im        in   DATA_W signed sample
//   in_inverse          in   frame mode (1 = inverse), taken with sample 0
//   out_valid/out_ready out/in output bin handshake
//   out_re, out_im      out  OUT_W signed bin
//   out_idx             out  bin index 0..3
//   out_last            out  high with bin 3
// Optional feature macro: FFT4_SCALE_EN (each stage >>1, total 1/4).
// -----------------------------------------------------------------------------
module fft4_stream
   import fft_pkg::*;
#(
   parameter  int DATA_W = 16,
   localparam int OUT_W  = out_width(DATA_W)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   input  logic                     in_inverse,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_re,
   output logic signed [OUT_W-1:0]  out_im,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_last
);

   localparam int S1_W = SCALE_EN ? DATA_W : DATA_W + 1;
   // Stage-2 operands carry one extra bit so that negating d_re for the -j
   // rotation cannot wrap (d_re may sit at the most negative S1_W value).
   localparam int R_W  = S1_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT4_N - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t           state, state_nx;
   logic [IDX_W-1:0] cnt;
   logic             inv;

   logic signed [DATA_W-1:0] x_re [FFT4_N];
   logic signed [DATA_W-1:0] x_im [FFT4_N];

   // Stage-1 registers: a = x0+x2, b = x0-x2, c = x1+x3, d = x1-x3
   logic signed [S1_W-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
   // Stage-2 registers: bins in natural order, mode swap already applied
   logic signed [OUT_W-1:0] y_re [FFT4_N];
   logic signed [OUT_W-1:0] y_im [FFT4_N];

   // Stage-1 butterfly outputs
   logic signed [S1_W-1:0] a_re_n, a_im_n, b_re_n, b_im_n;
   logic signed [S1_W-1:0] c_re_n, c_im_n, d_re_n, d_im_n;
   // Stage-2 butterfly inputs/outputs
   logic signed [R_W-1:0]  bx_re, bx_im, rot_re, rot_im;
   logic signed [OUT_W-1:0] x0_re, x0_im, x2_re, x2_im;
   logic signed [OUT_W-1:0] x1_re, x1_im, x3_re, x3_im;

   // ---------------------------------------------------------------- stage 1
   fft_bfly2 #(.IN_W(DATA_W), .OUT_W(S1_W)) u_bfly_ab (
      .a_re(x_re[0]), .a_im(x_im[0]), .b_re(x_re[2]), .b_im(x_im[2]),
      .sum_re(a_re_n), .sum_im(a_im_n), .dif_re(b_re_n), .dif_im(b_im_n)
   );

   fft_bfly2 #(.IN_W(DATA_W), .OUT_W(S1_W)) u_bfly_cd (
      .a_re(x_re[1]), .a_im(x_im[1]), .b_re(x_re[3]), .b_im(x_im[3]),
      .sum_re(c_re_n), .sum_im(c_im_n), .dif_re(d_re_n), .dif_im(d_im_n)
   );

   // ---------------------------------------------------------------- stage 2
   // -j * d = (d_im, -d_re); then X1 = b + (-j d), X3 = b - (-j d).
   assign bx_re  = R_W'(b_re);
   assign bx_im  = R_W'(b_im);
   assign rot_re = R_W'(d_im);
   assign rot_im = -R_W'(d_re);

   fft_bfly2 #(.IN_W(S1_W), .OUT_W(OUT_W)) u_bfly_02 (
      .a_re(a_re), .a_im(a_im), .b_re(c_re), .b_im(c_im),
      .sum_re(x0_re), .sum_im(x0_im), .dif_re(x2_re), .dif_im(x2_im)
   );

   fft_bfly2 #(.IN_W(R_W), .OUT_W(OUT_W)) u_bfly_13 (
      .a_re(bx_re), .a_im(bx_im), .b_re(rot_re), .b_im(rot_im),
      .sum_re(x1_re), .sum_im(x1_im), .dif_re(x3_re), .dif_im(x3_im)
   );

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_re    = '0;
      out_im    = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && cnt == LAST_IDX) state_nx = STAGE1;
         end
         STAGE1: state_nx = STAGE2;
         STAGE2: state_nx = UNLOAD;
         UNLOAD: begin
            out_valid = 1'b1;
            out_re    = y_re[cnt];
            out_im    = y_im[cnt];
            out_idx   = cnt;
            out_last  = (cnt == LAST_IDX);
            if (out_ready && cnt == LAST_IDX) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   // ------------------------------------------------------------- datapath
   // cnt indexes samples in LOAD and bins in UNLOAD; it wraps 3 -> 0 on the
   // final accept/transfer, so it is already 0 for the next phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         inv  <= 1'b0;
         a_re <= '0; a_im <= '0; b_re <= '0; b_im <= '0;
         c_re <= '0; c_im <= '0; d_re <= '0; d_im <= '0;
         for (int i = 0; i < FFT4_N; i++) begin
            x_re[i] <= '0;
            x_im[i] <= '0;
            y_re[i] <= '0;
            y_im[i] <= '0;
         end
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  x_re[cnt] <= in_re;
                  x_im[cnt] <= in_im;
                  if (cnt == '0) inv <= in_inverse;
                  cnt <= cnt + IDX_ONE;
               end
            end
            STAGE1: begin
               a_re <= a_re_n; a_im <= a_im_n;
               b_re <= b_re_n; b_im <= b_im_n;
               c_re <= c_re_n; c_im <= c_im_n;
               d_re <= d_re_n; d_im <= d_im_n;
            end
            STAGE2: begin
               y_re[0] <= x0_re;
               y_im[0] <= x0_im;
               y_re[2] <= x2_re;
               y_im[2] <= x2_im;
               // Inverse DFT uses +j rotation, which just exchanges X1/X3.
               y_re[1] <= inv ? x3_re : x1_re;
               y_im[1] <= inv ? x3_im : x1_im;
               y_re[3] <= inv ? x1_re : x3_re;
               y_im[3] <= inv ? x1_im : x3_im;
            end
            UNLOAD: begin
               if (out_ready) cnt <= cnt + IDX_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule
